spi_slv_sel_auto: RTL and testbench
===================================

# spi_slv_sel_auto

Parametrised SPI slave-select controller on the AVR I/O bus. It succeeds the fixed manual select register. Manual mode drives the select lines straight from a CPU-written mask. Auto mode frames a multi-byte SPI transaction in hardware, with programmable setup, hold and inter-frame gap times. The block sits between the CPU I/O bus and the SPI core, and gates the SPI core's start of each byte.

## Interface
- num_of_slvs, 7: number of select lines, 1..8.
- SLSEL_Address, 6'h00: address of the select-mask register.
- SLCTL_Address, 6'h01: address of the control/status register.
- SLDLY_Address, 6'h02: address of the delay register.
- The integrator maps the three addresses to free I/O locations.
- Reset decision: reset ireset, asynchronous, active-low.
- ireset  in  1  asynchronous active-low reset.
- cp2  in  1  clock; all state updates on its rising edge.
- adr  in  6  I/O address.
- dbus_in  in  8  I/O write data.
- dbus_out  out  8  I/O read data; unused bits read 0.
- iore  in  1  I/O read strobe.
- iowe  in  1  I/O write strobe.
- out_en  out  1  high when iore=1 and adr matches any of the three addresses.
- spi_req  in  1  one-cycle pulse from the SPI core when the CPU writes its data register.
- spi_go  out  1  one-cycle pulse telling the SPI core to start shifting a byte.
- spi_done  in  1  one-cycle pulse from the SPI core at the end of each byte.
- slv_sel_n  out  num_of_slvs  active-low select lines.

## Operation
- SLSEL[num_of_slvs-1:0]: select mask, read/write.
- SLCTL bit7 AUTO: read/write.
- SLCTL bit6 BUSY: read-only; 1 when the state is not IDLE.
- SLCTL bit5 OVR: sticky flag; writing 1 clears it.
- SLCTL bits3:0 NB: bytes per frame; 0 means 16.
- SLDLY bits7:4 S: setup cycles. SLDLY bits3:0 H: hold cycles and gap cycles.
- Manual mode (AUTO=0):
  - slv_sel_n = ~SLSEL.
  - spi_go = spi_req delayed by one register stage.
  - The FSM is held in IDLE.
- Auto mode (AUTO=1) FSM, with 4-bit delay counter cnt and 5-bit byte counter bl:
  - IDLE: slv_sel_n all 1. On spi_req or a pending request: latch act_mask=SLSEL, set bl=NB (16 if NB=0), set cnt=S, clear pending, go SETUP.
  - SETUP: slv_sel_n=~act_mask. If cnt=0, pulse spi_go and go XFER; otherwise decrement cnt.
  - XFER: on spi_done, decrement bl. If the new bl=0, set cnt=H and go HOLD; otherwise go WAIT.
  - WAIT: select stays asserted. On spi_req, pulse spi_go in the next cycle and go XFER.
  - HOLD: select stays asserted. If cnt=0, set cnt=H and go GAP; otherwise decrement.
  - GAP: slv_sel_n all 1. If cnt=0, go IDLE; otherwise decrement.
- Event handling:
  - spi_req in HOLD or GAP sets pending, which is served on return to IDLE.
  - spi_req in SETUP or XFER is ignored and sets OVR.
  - spi_req in HOLD/GAP while pending is already 1 also sets OVR.
- Register-write interactions:
  - Writing SLSEL mid-frame updates the register only; act_mask is unchanged until the next frame.
  - Writing AUTO=0 in any state forces IDLE next cycle: selects deassert, pending clears, no spi_go is issued.
  - A write that sets OVR in the same cycle as a clear-write leaves OVR=1.
- Status: BUSY = (state != IDLE).

## Timing
- Reset values:
  - SLSEL=0, SLCTL=0, SLDLY=0, state IDLE, pending=0, OVR=0.
  - slv_sel_n all 1, spi_go=0.
  - dbus_out and out_en follow combinationally from adr and iore.
- Register writes take effect at the rising edge of cp2 at the end of the iowe cycle.
- Manual-mode slv_sel_n changes one cycle after the write.
- Auto-mode latencies:
  - slv_sel_n asserts 1 cycle after spi_req.
  - spi_go pulses S+1 cycles after spi_req.
  - Deassertion occurs H+1 cycles after the last spi_done.
  - The earliest next assertion is 2H+3 cycles after the last spi_done.
- spi_go is exactly one cycle wide and is registered; spi_done is sampled only in XFER.
- Asynchronous reset mid-frame: slv_sel_n goes to all 1 immediately, without waiting for a clock edge.

## Test plan
- Manual mode, num_of_slvs=7: write SLSEL=0x05 → slv_sel_n=7'b1111010 next cycle; read gives dbus_out=0x05 and out_en=1.
- Auto mode, NB=2, S=3, H=2, SLSEL=0x01:
  - spi_req → slv_sel_n[0]=0 at +1 and spi_go at +4.
  - spi_done, then spi_req → spi_go 1 cycle after that spi_req.
  - Second spi_done → select released 3 cycles later; BUSY=0 after the gap.
- spi_req during XFER → no spi_go and OVR=1; writing SLCTL with bit5=1 (keeping AUTO=1) → OVR=0.
- spi_req during HOLD → pending set; a new frame starts right after GAP ends, with spi_go S+1 cycles after entering IDLE+1.
- Abort: write AUTO=0 in WAIT → slv_sel_n all 1 next cycle and no further spi_go.
- Edge cases: NB=0 gives a 16-byte frame; S=H=0 gives spi_go at +1; asserting ireset mid-frame returns all registers to 0.

Source files
------------

// File: rtl/spi_slv_sel_auto.sv
// SPI slave-select controller on the AVR I/O bus.
// Manual mode drives the selects from a CPU mask; auto mode frames a
// multi-byte transfer in hardware with setup, hold and inter-frame gap
// delays, and gates the SPI core's start of each byte through spi_go.
module spi_slv_sel_auto #(
  parameter int          num_of_slvs   = 7,
  parameter logic [5:0]  SLSEL_Address = 6'h00,
  parameter logic [5:0]  SLCTL_Address = 6'h01,
  parameter logic [5:0]  SLDLY_Address = 6'h02
) (
  input  logic                   ireset,
  input  logic                   cp2,
  input  logic [5:0]             adr,
  input  logic [7:0]             dbus_in,
  output logic [7:0]             dbus_out,
  input  logic                   iore,
  input  logic                   iowe,
  output logic                   out_en,
  input  logic                   spi_req,
  output logic                   spi_go,
  input  logic                   spi_done,
  output logic [num_of_slvs-1:0] slv_sel_n
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_XFER, S_WAIT, S_HOLD, S_GAP
  } state_t;

  // CPU-visible registers
  logic [num_of_slvs-1:0] slsel_q;
  logic                   auto_q;
  logic                   ovr_q;
  logic                   ovr_d;
  logic [3:0]             nb_q;
  logic [7:0]             sldly_q;

  // frame sequencer state
  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [4:0]             bl_q, bl_d;
  logic [num_of_slvs-1:0] act_mask_q, act_mask_d;
  logic                   pending_q, pending_d;
  logic                   go_q, go_d;
  logic                   ovr_set;

  logic                   wr_slsel, wr_slctl, wr_sldly;
  logic [3:0]             dly_s, dly_h;
  logic [7:0]             slsel_rd;

  assign wr_slsel = iowe && (adr == SLSEL_Address);
  assign wr_slctl = iowe && (adr == SLCTL_Address);
  assign wr_sldly = iowe && (adr == SLDLY_Address);
  assign dly_s    = sldly_q[7:4];
  assign dly_h    = sldly_q[3:0];
  assign spi_go   = go_q;

  // Sticky overrun: a new overrun wins over a simultaneous clear-write.
  assign ovr_d = (ovr_q && !(wr_slctl && dbus_in[5])) || ovr_set;

  // CPU register file writes
  always_ff @(posedge cp2 or negedge ireset) begin
    if (!ireset) begin
      slsel_q <= '0;
      auto_q  <= 1'b0;
      ovr_q   <= 1'b0;
      nb_q    <= 4'd0;
      sldly_q <= 8'd0;
    end else begin
      if (wr_slsel) slsel_q <= dbus_in[num_of_slvs-1:0];
      if (wr_slctl) begin
        auto_q <= dbus_in[7];
        nb_q   <= dbus_in[3:0];
      end
      if (wr_sldly) sldly_q <= dbus_in;
      ovr_q <= ovr_d;
    end
  end

  // Sequencer state register
  always_ff @(posedge cp2 or negedge ireset) begin
    if (!ireset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      bl_q       <= 5'd0;
      act_mask_q <= '0;
      pending_q  <= 1'b0;
      go_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bl_q       <= bl_d;
      act_mask_q <= act_mask_d;
      pending_q  <= pending_d;
      go_q       <= go_d;
    end
  end

  // Next-state logic; go_d is computed one cycle ahead so spi_go is a
  // registered pulse that lines up with the last setup cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bl_d       = bl_q;
    act_mask_d = act_mask_q;
    pending_d  = pending_q;
    go_d       = 1'b0;
    ovr_set    = 1'b0;
    if (!auto_q) begin
      state_d   = S_IDLE;
      pending_d = 1'b0;
      go_d      = spi_req;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (spi_req || pending_q) begin
            act_mask_d = slsel_q;
            bl_d       = (nb_q == 4'd0) ? 5'd16 : {1'b0, nb_q};
            cnt_d      = dly_s;
            pending_d  = 1'b0;
            state_d    = S_SETUP;
            go_d       = (dly_s == 4'd0);
          end
        end
        S_SETUP: begin
          if (spi_req) ovr_set = 1'b1;
          if (cnt_q == 4'd0) begin
            state_d = S_XFER;
          end else begin
            cnt_d = cnt_q - 4'd1;
            go_d  = (cnt_q == 4'd1);
          end
        end
        S_XFER: begin
          if (spi_req) ovr_set = 1'b1;
          if (spi_done) begin
            bl_d = bl_q - 5'd1;
            if (bl_q == 5'd1) begin
              // Hold spans H cycles so the select releases H+1 cycles
              // after the last spi_done; H=0 skips straight to the gap.
              if (dly_h == 4'd0) begin
                state_d = S_GAP;
                cnt_d   = 4'd0;
              end else begin
                state_d = S_HOLD;
                cnt_d   = dly_h - 4'd1;
              end
            end else begin
              state_d = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (spi_req) begin
            go_d    = 1'b1;
            state_d = S_XFER;
          end
        end
        S_HOLD, S_GAP: begin
          if (spi_req) begin
            if (pending_q) ovr_set = 1'b1;
            else           pending_d = 1'b1;
          end
          if (cnt_q == 4'd0) begin
            state_d = (state_q == S_HOLD) ? S_GAP : S_IDLE;
            cnt_d   = (state_q == S_HOLD) ? dly_h : 4'd0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
      // Dropping AUTO aborts the frame outright.
      if (wr_slctl && !dbus_in[7]) begin
        state_d   = S_IDLE;
        pending_d = 1'b0;
        go_d      = 1'b0;
      end
    end
  end

  // Select outputs follow register state, so reset releases them at once.
  always_comb begin
    slv_sel_n = '1;
    if (!auto_q) begin
      slv_sel_n = ~slsel_q;
    end else if (state_q == S_SETUP || state_q == S_XFER ||
                 state_q == S_WAIT  || state_q == S_HOLD) begin
      slv_sel_n = ~act_mask_q;
    end
  end

  // I/O read mux; unimplemented bits and non-selected reads return 0
  always_comb begin
    slsel_rd                  = 8'd0;
    slsel_rd[num_of_slvs-1:0] = slsel_q;
    dbus_out                  = 8'd0;
    out_en                    = 1'b0;
    if (iore) begin
      if (adr == SLSEL_Address) begin
        dbus_out = slsel_rd;
        out_en   = 1'b1;
      end else if (adr == SLCTL_Address) begin
        dbus_out = {auto_q, (state_q != S_IDLE), ovr_q, 1'b0, nb_q};
        out_en   = 1'b1;
      end else if (adr == SLDLY_Address) begin
        dbus_out = sldly_q;
        out_en   = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_slv_sel_auto.sv
// Testbench for spi_slv_sel_auto: register vectors, timed auto-mode
// frames against an event-time plan, corner-case sequences and random
// manual-mode traffic against a register model.
module tb_spi_slv_sel_auto;
  localparam int N = 7;

  logic         clk = 1'b0;
  logic         ireset;
  logic [5:0]   adr;
  logic [7:0]   dbus_in, dbus_out;
  logic         iore, iowe, out_en;
  logic         spi_req, spi_go, spi_done;
  logic [N-1:0] slv_sel_n;

  always #5 clk = ~clk;

  spi_slv_sel_auto #(
    .num_of_slvs(N), .SLSEL_Address(6'h00),
    .SLCTL_Address(6'h01), .SLDLY_Address(6'h02)
  ) dut (
    .ireset(ireset), .cp2(clk), .adr(adr), .dbus_in(dbus_in),
    .dbus_out(dbus_out), .iore(iore), .iowe(iowe), .out_en(out_en),
    .spi_req(spi_req), .spi_go(spi_go), .spi_done(spi_done),
    .slv_sel_n(slv_sel_n)
  );

  int nvec = 0;
  int nmis = 0;

  logic [N-1:0] o_sel;
  logic         o_go, o_oen;
  logic [7:0]   o_dout;

  typedef struct {
    logic we; logic re; logic [5:0] adr; logic [7:0] din; logic req;
    logic [7:0] e_dout; logic e_oen; logic [N-1:0] e_sel; logic e_go;
  } vec_t;
  vec_t vt[$];

  function automatic vec_t mk(logic we, logic re, logic [5:0] a, logic [7:0] din,
                              logic req, logic [7:0] ed, logic eo,
                              logic [N-1:0] es, logic eg);
    vec_t x;
    x.we = we; x.re = re; x.adr = a; x.din = din; x.req = req;
    x.e_dout = ed; x.e_oen = eo; x.e_sel = es; x.e_go = eg;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, sample outputs mid-cycle, advance.
  task automatic step(input logic req, input logic done, input logic we,
                      input logic re, input logic [5:0] a, input logic [7:0] d);
    spi_req = req; spi_done = done; iowe = we; iore = re; adr = a; dbus_in = d;
    @(negedge clk);
    o_sel = slv_sel_n; o_go = spi_go; o_dout = dbus_out; o_oen = out_en;
    @(posedge clk); #1;
    spi_req = 1'b0; spi_done = 1'b0; iowe = 1'b0; iore = 1'b0;
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    step(1'b0, 1'b0, 1'b1, 1'b0, a, d);
  endtask

  // Idle/event cycle that reads the control/status register.
  task automatic st(input logic req, input logic done);
    step(req, done, 1'b0, 1'b1, 6'h01, 8'h00);
  endtask

  // Auto-mode frame checked against a plan of event times:
  // select on from cycle 1 to D+H, busy to D+2H+1, spi_go at S+1 and
  // one cycle after each follow-on request.
  task automatic run_frame(input int s, input int h, input int nb_f,
                           input logic [N-1:0] mask, input bit rnd, input string tag);
    int g[16], d[16], r[16];
    int nb, dl, last;
    wr(6'h00, 8'(mask));
    wr(6'h02, {4'(s), 4'(h)});
    wr(6'h01, {1'b1, 3'b000, 4'(nb_f)});
    nb = (nb_f == 0) ? 16 : nb_f;
    g[0] = s + 1;
    for (int i = 0; i < nb; i++) begin
      d[i] = g[i] + (rnd ? int'($urandom_range(1, 3)) : 2);
      if (i < nb - 1) begin
        r[i] = d[i] + (rnd ? int'($urandom_range(1, 3)) : 2);
        g[i+1] = r[i] + 1;
      end else begin
        r[i] = -1;
      end
    end
    dl = d[nb-1];
    last = dl + 2*h + 3;
    for (int c = 0; c <= last; c++) begin
      bit rq, dn, eg;
      logic busy;
      logic [N-1:0] es;
      rq = (c == 0); dn = 1'b0; eg = 1'b0;
      for (int i = 0; i < nb; i++) begin
        if (r[i] == c) rq = 1'b1;
        if (d[i] == c) dn = 1'b1;
        if (g[i] == c) eg = 1'b1;
      end
      st(rq, dn);
      es   = (c >= 1 && c <= dl + h) ? ~mask : '1;
      busy = (c >= 1 && c <= dl + 2*h + 1);
      chk($sformatf("%s c%0d sel/go/ctl", tag, c), {o_sel, o_go, o_dout},
          {es, eg, 1'b1, busy, 2'b00, 4'(nb_f)});
    end
  endtask

  initial begin
    logic [N-1:0] sel_h[32];
    logic         go_h[32];
    logic [7:0]   dout_h[32];
    logic [N-1:0] m_sel;
    logic [7:0]   m_dly, e_dout;
    logic [3:0]   m_nb;
    logic         prev, e_oen;

    ireset = 1'b0; adr = 6'h00; dbus_in = 8'h00; iore = 1'b0; iowe = 1'b0;
    spi_req = 1'b0; spi_done = 1'b0;
    repeat (3) @(posedge clk);
    #1 ireset = 1'b1;

    // ---- manual-mode register vectors ----
    vt.push_back(mk(0,1,6'h00,8'h00,0, 8'h00,1,7'h7F,0));
    vt.push_back(mk(0,1,6'h01,8'h00,0, 8'h00,1,7'h7F,0));
    vt.push_back(mk(0,1,6'h02,8'h00,0, 8'h00,1,7'h7F,0));
    vt.push_back(mk(0,0,6'h00,8'h00,0, 8'h00,0,7'h7F,0));
    vt.push_back(mk(1,0,6'h00,8'h05,0, 8'h00,0,7'h7F,0));
    vt.push_back(mk(0,1,6'h00,8'h00,0, 8'h05,1,7'h7A,0));
    vt.push_back(mk(0,1,6'h03,8'h00,0, 8'h00,0,7'h7A,0));
    vt.push_back(mk(1,0,6'h00,8'hFF,0, 8'h00,0,7'h7A,0));
    vt.push_back(mk(0,1,6'h00,8'h00,0, 8'h7F,1,7'h00,0));
    vt.push_back(mk(0,0,6'h00,8'h00,1, 8'h00,0,7'h00,0));
    vt.push_back(mk(0,0,6'h00,8'h00,0, 8'h00,0,7'h00,1));
    vt.push_back(mk(0,0,6'h00,8'h00,0, 8'h00,0,7'h00,0));
    vt.push_back(mk(1,0,6'h02,8'hA5,0, 8'h00,0,7'h00,0));
    vt.push_back(mk(0,1,6'h02,8'h00,0, 8'hA5,1,7'h00,0));
    vt.push_back(mk(1,0,6'h01,8'h5F,0, 8'h00,0,7'h00,0));
    vt.push_back(mk(0,1,6'h01,8'h00,0, 8'h0F,1,7'h00,0));
    vt.push_back(mk(1,0,6'h00,8'h00,0, 8'h00,0,7'h00,0));
    vt.push_back(mk(0,1,6'h00,8'h00,1, 8'h00,1,7'h7F,0));
    vt.push_back(mk(0,1,6'h01,8'h00,0, 8'h0F,1,7'h7F,1));
    foreach (vt[i]) begin
      step(vt[i].req, 1'b0, vt[i].we, vt[i].re, vt[i].adr, vt[i].din);
      chk($sformatf("vec%0d dout/oen/sel/go", i), {o_dout, o_oen, o_sel, o_go},
          {vt[i].e_dout, vt[i].e_oen, vt[i].e_sel, vt[i].e_go});
    end

    // ---- auto-mode frames ----
    run_frame(3, 2, 2, 7'h01, 1'b0, "plan");
    run_frame(0, 0, 1, 7'h55, 1'b0, "s0h0");
    run_frame(0, 0, 0, 7'h40, 1'b1, "nb16");
    for (int k = 0; k < 6; k++)
      run_frame(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(1, 4)), 7'($urandom_range(1, 127)), 1'b1,
                $sformatf("rnd%0d", k));

    // ---- overrun during XFER and clear ----
    wr(6'h00, 8'h01); wr(6'h02, 8'h00); wr(6'h01, 8'h81);
    st(1'b1, 1'b0);
    st(1'b0, 1'b0); chk("ovr go at +1", o_go, 1'b1);
    st(1'b0, 1'b0);
    st(1'b1, 1'b0);
    st(1'b0, 1'b0); chk("ovr no go/ctl", {o_go, o_dout}, {1'b0, 8'hE1});
    st(1'b0, 1'b1);
    st(1'b0, 1'b0);
    st(1'b0, 1'b0); chk("ovr sticky idle", o_dout, 8'hA1);
    wr(6'h01, 8'hA1);
    st(1'b0, 1'b0); chk("ovr cleared", o_dout, 8'h81);
    // set and clear in the same cycle: set wins
    st(1'b1, 1'b0); st(1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 6'h01, 8'hA1);
    st(1'b0, 1'b0); chk("ovr set beats clear", o_dout, 8'hE1);
    st(1'b0, 1'b1); st(1'b0, 1'b0); st(1'b0, 1'b0);
    wr(6'h01, 8'hA1);
    st(1'b0, 1'b0); chk("ovr cleared again", o_dout, 8'h81);

    // ---- pending request in HOLD, double request in GAP ----
    wr(6'h00, 8'h06); wr(6'h02, 8'h12); wr(6'h01, 8'h81);
    for (int c = 0; c < 22; c++) begin
      st(c == 0 || c == 5 || c == 8, c == 4 || c == 14);
      sel_h[c] = o_sel; go_h[c] = o_go; dout_h[c] = o_dout;
    end
    chk("pend go first", go_h[2], 1'b1);
    chk("pend hold ctl", dout_h[5], 8'hC1);
    chk("pend hold sel", sel_h[6], 7'h79);
    chk("pend gap sel", sel_h[7], 7'h7F);
    chk("pend ovr before", dout_h[8], 8'hC1);
    chk("pend ovr after", dout_h[9], 8'hE1);
    chk("pend idle ctl", dout_h[10], 8'hA1);
    chk("pend idle sel", sel_h[10], 7'h7F);
    chk("pend reassert", sel_h[11], 7'h79);
    chk("pend go2 timing", {go_h[11], go_h[12]}, 2'b01);
    chk("pend end ctl", {dout_h[19], dout_h[20]}, {8'hE1, 8'hA1});
    wr(6'h01, 8'h21);

    // ---- abort with AUTO=0 while waiting for the next byte ----
    wr(6'h00, 8'h01); wr(6'h02, 8'h00); wr(6'h01, 8'h82);
    st(1'b1, 1'b0); st(1'b0, 1'b0); st(1'b0, 1'b0);
    st(1'b0, 1'b1);
    wr(6'h00, 8'h00);
    wr(6'h01, 8'h02); chk("abort mask kept", o_sel, 7'h7E);
    for (int c = 0; c < 4; c++) begin
      st(1'b0, 1'b0);
      chk($sformatf("abort c%0d sel/go/ctl", c), {o_sel, o_go, o_dout}, {7'h7F, 1'b0, 8'h02});
    end

    // ---- asynchronous reset mid-frame ----
    wr(6'h00, 8'h7F); wr(6'h02, 8'h00); wr(6'h01, 8'h83);
    st(1'b1, 1'b0);
    chk("rst pre sel", slv_sel_n, 7'h00);
    #2 ireset = 1'b0;
    #1 chk("rst async sel/go", {slv_sel_n, spi_go}, {7'h7F, 1'b0});
    iore = 1'b1; adr = 6'h00;
    #1 chk("rst slsel", dbus_out, 8'h00);
    adr = 6'h01;
    #1 chk("rst slctl", dbus_out, 8'h00);
    adr = 6'h02;
    #1 chk("rst sldly", dbus_out, 8'h00);
    iore = 1'b0;
    @(posedge clk); #1 ireset = 1'b1;
    st(1'b0, 1'b0); chk("rst after", {o_sel, o_go, o_dout}, {7'h7F, 1'b0, 8'h00});

    // ---- random manual-mode traffic against a register model ----
    m_sel = '0; m_dly = 8'h00; m_nb = 4'h0; prev = 1'b0;
    for (int c = 0; c < 60; c++) begin
      int op, a;
      logic [7:0] dat;
      logic rq;
      op = int'($urandom_range(0, 2)); a = int'($urandom_range(0, 3));
      dat = 8'($urandom); rq = 1'($urandom_range(0, 1));
      if (a == 1) dat[7] = 1'b0;
      step(rq, 1'b0, op == 0, op == 1, 6'(a), dat);
      e_dout = 8'h00; e_oen = 1'b0;
      if (op == 1) begin
        case (a)
          0: e_dout = 8'(m_sel);
          1: e_dout = {4'h0, m_nb};
          2: e_dout = m_dly;
          default: e_dout = 8'h00;
        endcase
        e_oen = (a != 3);
      end
      chk($sformatf("man%0d op%0d a%0d", c, op, a), {o_dout, o_oen, o_sel, o_go},
          {e_dout, e_oen, ~m_sel, prev});
      if (op == 0) begin
        if (a == 0) m_sel = dat[N-1:0];
        if (a == 1) m_nb  = dat[3:0];
        if (a == 2) m_dly = dat;
      end
      prev = rq;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
